// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : Control/status register file for a LoongArch-style pipeline.
//               It holds the privilege and exception state, the interrupt
//               status and enable bits, four scratch registers, and a
//               down-counting timer. Reads are combinational. Writes are
//               masked and take effect on the next edge. Exception entry and
//               return are committed from WB.
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               csr_re, csr_num, csr_rvalue - combinational read port
//               csr_we, csr_wmask, csr_wvalue - masked write port
//               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr - exception report
//               ertn_flush                 - exception-return commit
//               hw_int_in, ipi_int_in      - level interrupt inputs
//               csr_plv, has_int           - privilege level, interrupt request
//               ex_entry, ertn_entry       - EENTRY / ERA redirect targets
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter int unsigned CSR_NUM_WIDTH = 14,
    parameter logic [31:0] TIMER_ID      = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_re,
    input  logic [CSR_NUM_WIDTH-1:0] csr_num,
    output logic [31:0]              csr_rvalue,
    input  logic                     csr_we,
    input  logic [31:0]              csr_wmask,
    input  logic [31:0]              csr_wvalue,
    input  logic                     wb_ex,
    input  logic [5:0]               wb_ecode,
    input  logic [8:0]               wb_esubcode,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_vaddr,
    input  logic                     ertn_flush,
    input  logic [7:0]               hw_int_in,
    input  logic                     ipi_int_in,
    output logic [1:0]               csr_plv,
    output logic                     has_int,
    output logic [31:0]              ex_entry,
    output logic [31:0]              ertn_entry
);

    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_crmd   = CSR_NUM_WIDTH'(16'h0000);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_prmd   = CSR_NUM_WIDTH'(16'h0001);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_ecfg   = CSR_NUM_WIDTH'(16'h0004);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_estat  = CSR_NUM_WIDTH'(16'h0005);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_era    = CSR_NUM_WIDTH'(16'h0006);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_badv   = CSR_NUM_WIDTH'(16'h0007);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_eentry = CSR_NUM_WIDTH'(16'h000C);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_save0  = CSR_NUM_WIDTH'(16'h0030);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_save1  = CSR_NUM_WIDTH'(16'h0031);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_save2  = CSR_NUM_WIDTH'(16'h0032);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_save3  = CSR_NUM_WIDTH'(16'h0033);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_tid    = CSR_NUM_WIDTH'(16'h0040);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_tcfg   = CSR_NUM_WIDTH'(16'h0041);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_tval   = CSR_NUM_WIDTH'(16'h0042);
    localparam logic [CSR_NUM_WIDTH-1:0] c_addr_ticlr  = CSR_NUM_WIDTH'(16'h0044);

    localparam logic [5:0]  c_ecode_ade = 6'h08;
    // LIE bit 10 has no interrupt source behind it and is held at zero.
    localparam logic [12:0] c_lie_mask  = 13'h1BFF;

    // Architectural state, stored as the writable or hardware fields only.
    logic [4:0]  r_crmd;        // PG, DA, IE, PLV[1:0]
    logic [2:0]  r_prmd;        // PIE, PPLV[1:0]
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_timer;
    logic        r_is_ipi;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [25:0] r_eentry;
    logic [31:0] r_save [0:3];
    logic [31:0] r_tid;
    logic [31:0] r_tcfg;        // InitVal[31:2], Periodic[1], En[0]
    logic [31:0] r_tval;

    logic [31:0] w_rdata;
    logic [31:0] w_wdata;
    logic        w_wen;
    logic        w_ex_take;
    logic        w_wr_tcfg;
    logic        w_ticlr;
    logic        w_timer_fire;
    logic        w_unused_re;

    // The read strobe only marks the access. The read port is always live.
    assign w_unused_re = csr_re;

    // A commit of an exception or an exception return blocks the
    // instruction's own CSR write. An ertn also masks a coincident exception.
    assign w_wen     = csr_we & ~wb_ex & ~ertn_flush;
    assign w_ex_take = wb_ex & ~ertn_flush;

    // The read mux already selects the addressed register, so the masked
    // merge is done once here. Each register takes only its writable slice.
    assign w_wdata = (w_rdata & ~csr_wmask) | (csr_wvalue & csr_wmask);

    assign w_wr_tcfg    = w_wen && (csr_num == c_addr_tcfg);
    assign w_ticlr      = w_wen && (csr_num == c_addr_ticlr) && csr_wvalue[0] && csr_wmask[0];
    // A TCFG write reloads the counter, so that cycle never fires.
    assign w_timer_fire = r_tcfg[0] && !w_wr_tcfg && (r_tval == 32'd1);

    always_comb begin
        w_rdata = 32'h0;
        case (csr_num)
            c_addr_crmd:   w_rdata = {27'h0, r_crmd};
            c_addr_prmd:   w_rdata = {29'h0, r_prmd};
            c_addr_ecfg:   w_rdata = {19'h0, r_ecfg_lie};
            c_addr_estat:  w_rdata = {1'b0, r_esubcode, r_ecode, 3'b000, r_is_ipi,
                                      r_is_timer, 1'b0, r_is_hw, r_is_sw};
            c_addr_era:    w_rdata = r_era;
            c_addr_badv:   w_rdata = r_badv;
            c_addr_eentry: w_rdata = {r_eentry, 6'h00};
            c_addr_save0:  w_rdata = r_save[0];
            c_addr_save1:  w_rdata = r_save[1];
            c_addr_save2:  w_rdata = r_save[2];
            c_addr_save3:  w_rdata = r_save[3];
            c_addr_tid:    w_rdata = r_tid;
            c_addr_tcfg:   w_rdata = r_tcfg;
            c_addr_tval:   w_rdata = r_tval;
            default:       w_rdata = 32'h0;   // TICLR and unmapped addresses
        endcase
    end

    assign csr_rvalue = w_rdata;
    assign csr_plv    = r_crmd[1:0];
    assign ex_entry   = {r_eentry, 6'h00};
    assign ertn_entry = r_era;
    assign has_int    = (({r_is_ipi, r_is_timer, 1'b0, r_is_hw, r_is_sw} & r_ecfg_lie) != 13'h0)
                        && r_crmd[2];

    // Privilege and exception context
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crmd     <= 5'h08;
            r_prmd     <= 3'h0;
            r_era      <= 32'h0;
            r_badv     <= 32'h0;
            r_ecode    <= 6'h0;
            r_esubcode <= 9'h0;
        end else if (ertn_flush) begin
            r_crmd[2:0] <= r_prmd;
        end else if (w_ex_take) begin
            r_prmd      <= r_crmd[2:0];
            r_crmd[2:0] <= 3'b000;
            r_era       <= wb_pc;
            r_ecode     <= wb_ecode;
            r_esubcode  <= wb_esubcode;
            if (wb_ecode == c_ecode_ade) begin
                r_badv <= wb_vaddr;
            end
        end else if (w_wen) begin
            if (csr_num == c_addr_crmd) r_crmd <= w_wdata[4:0];
            if (csr_num == c_addr_prmd) r_prmd <= w_wdata[2:0];
            if (csr_num == c_addr_era)  r_era  <= w_wdata;
            if (csr_num == c_addr_badv) r_badv <= w_wdata;
        end
    end

    // Plain software-owned registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ecfg_lie <= 13'h0;
            r_is_sw    <= 2'b00;
            r_eentry   <= 26'h0;
            r_tid      <= TIMER_ID;
            r_tcfg     <= 32'h0;
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= 32'h0;
            end
        end else if (w_wen) begin
            if (csr_num == c_addr_ecfg)   r_ecfg_lie <= w_wdata[12:0] & c_lie_mask;
            if (csr_num == c_addr_estat)  r_is_sw    <= w_wdata[1:0];
            if (csr_num == c_addr_eentry) r_eentry   <= w_wdata[31:6];
            if (csr_num == c_addr_tid)    r_tid      <= w_wdata;
            if (csr_num == c_addr_tcfg)   r_tcfg     <= w_wdata;
            for (int i = 0; i < 4; i++) begin
                if (csr_num == c_addr_save0 + CSR_NUM_WIDTH'(i)) begin
                    r_save[i] <= w_wdata;
                end
            end
        end
    end

    // Interrupt status sampled from the pins every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_hw  <= 8'h0;
            r_is_ipi <= 1'b0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
        end
    end

    // Timer: the count goes from {InitVal,2'b00} down to 0. The step to 0
    // flags IS[11]. A periodic timer then sits one cycle at 0 before it
    // reloads, so the period is InitVal*4+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tval     <= 32'h0;
            r_is_timer <= 1'b0;
        end else begin
            if (w_wr_tcfg) begin
                r_tval <= {w_wdata[31:2], 2'b00};
            end else if (r_tcfg[0]) begin
                if (r_tval == 32'd0) begin
                    r_tval <= r_tcfg[1] ? {r_tcfg[31:2], 2'b00} : 32'h0;
                end else begin
                    r_tval <= r_tval - 32'd1;
                end
            end

            if (w_timer_fire) begin
                r_is_timer <= 1'b1;
            end else if (w_ticlr) begin
                r_is_timer <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file
// Description : Self-checking bench for csr_file. Directed scenarios plus a
//               randomized run, compared against a register-map model held
//               in an associative array keyed by CSR address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam int          W       = 14;
    localparam logic [31:0] TID_RST = 32'h0000_00A5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          csr_re = 1'b0;
    logic [W-1:0]  csr_num = '0;
    logic          csr_we = 1'b0;
    logic [31:0]   csr_wmask = '0;
    logic [31:0]   csr_wvalue = '0;
    logic          wb_ex = 1'b0;
    logic [5:0]    wb_ecode = '0;
    logic [8:0]    wb_esubcode = '0;
    logic [31:0]   wb_pc = '0;
    logic [31:0]   wb_vaddr = '0;
    logic          ertn_flush = 1'b0;
    logic [7:0]    hw_int_in = '0;
    logic          ipi_int_in = 1'b0;
    logic [31:0]   csr_rvalue;
    logic [1:0]    csr_plv;
    logic          has_int;
    logic [31:0]   ex_entry;
    logic [31:0]   ertn_entry;

    always #50 clk = ~clk;

    csr_file #(.CSR_NUM_WIDTH(W), .TIMER_ID(TID_RST)) dut (
        .clk(clk), .reset(reset),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .csr_plv(csr_plv), .has_int(has_int),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each architectural CSR is a full 32-bit word.
    logic [31:0] m [int];
    int          c_map [14] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C,
                                'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h42};
    int          c_rand_addr [17] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C,
                                     'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h42,
                                     'h44, 'h02, 'h100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_mask(input int a);
        case (a)
            'h00:    return 32'h0000_001F;
            'h01:    return 32'h0000_0007;
            'h04:    return 32'h0000_1BFF;
            'h05:    return 32'h0000_0003;
            'h0C:    return 32'hFFFF_FFC0;
            'h42:    return 32'h0000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a != 'h44 && m.exists(a)) return m[a];
        return 32'h0;
    endfunction

    function automatic logic model_has_int();
        logic [31:0] e;
        logic [31:0] c;
        logic [31:0] r;
        e = m['h05];
        c = m['h04];
        r = m['h00];
        return ((e[12:0] & c[12:0]) != 13'h0) && r[2];
    endfunction

    task automatic model_reset();
        foreach (c_map[i]) m[c_map[i]] = 32'h0;
        m['h00] = 32'h0000_0008;
        m['h40] = TID_RST;
    endtask

    // Next state from the current inputs, applied at the coming edge.
    task automatic model_step();
        int          a;
        logic        we_eff, set11, clr11;
        logic [31:0] crmd, prmd, estat, tcfg, tval, tval_next, wr;
        a = int'(csr_num);
        if (reset) begin
            model_reset();
            return;
        end
        crmd  = m['h00];
        prmd  = m['h01];
        estat = m['h05];
        tcfg  = m['h41];
        tval  = m['h42];
        we_eff = csr_we && !wb_ex && !ertn_flush;

        estat = (estat & ~32'h0000_13FC) | (32'(ipi_int_in) << 12) | (32'(hw_int_in) << 2);

        if (tcfg[0]) begin
            if (tval == 0) tval_next = tcfg[1] ? (tcfg >> 2) * 4 : 32'h0;
            else           tval_next = tval - 1;
        end else begin
            tval_next = tval;
        end
        set11 = tcfg[0] && (tval == 1) && !(we_eff && a == 'h41);
        clr11 = we_eff && (a == 'h44) && csr_wvalue[0] && csr_wmask[0];

        if (ertn_flush) begin
            crmd[2:0] = prmd[2:0];
        end else if (wb_ex) begin
            prmd[2:0] = crmd[2:0];
            crmd[2:0] = 3'b000;
            m['h06] = wb_pc;
            estat[21:16] = wb_ecode;
            estat[30:22] = wb_esubcode;
            if (wb_ecode == 6'h08) m['h07] = wb_vaddr;
        end
        m['h00] = crmd;
        m['h01] = prmd;
        m['h05] = estat;

        if (we_eff && a != 'h44 && m.exists(a)) begin
            wr = wr_mask(a) & csr_wmask;
            m[a] = (m[a] & ~wr) | (csr_wvalue & wr);
        end
        if (we_eff && a == 'h41) tval_next = m['h41] & 32'hFFFF_FFFC;
        m['h42] = tval_next;

        estat = m['h05];
        if (set11)      estat[11] = 1'b1;
        else if (clr11) estat[11] = 1'b0;
        m['h05] = estat;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic cycle();
        logic [31:0] crmd;
        #1;
        crmd = m['h00];
        chk("rvalue",     csr_rvalue, model_read(int'(csr_num)));
        chk("has_int",    32'(has_int), 32'(model_has_int()));
        chk("plv",        32'(csr_plv), 32'(crmd[1:0]));
        chk("ex_entry",   ex_entry,   m['h0C]);
        chk("ertn_entry", ertn_entry, m['h06]);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        csr_num = W'(a);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] mask, input logic [31:0] val);
        csr_we     = 1'b1;
        csr_num    = W'(a);
        csr_wmask  = mask;
        csr_wvalue = val;
        cycle();
        csr_we     = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        rd('h00); chk("rst_crmd",  csr_rvalue, 32'h0000_0008);
        rd('h40); chk("rst_tid",   csr_rvalue, TID_RST);
        rd('h05); chk("rst_estat", csr_rvalue, 32'h0);
        rd('h42); chk("rst_tval",  csr_rvalue, 32'h0);
        chk("rst_has_int", 32'(has_int), 32'h0);
        rd('h44); chk("ticlr_read", csr_rvalue, 32'h0);

        // Masked write and csrxchg-style read of the old value
        csr_we = 1'b1; csr_num = W'('h31); csr_wmask = 32'hFFFF_0000; csr_wvalue = 32'hDEAD_BEEF;
        #1; chk("save1_same_cycle", csr_rvalue, 32'h0);
        cycle();
        csr_we = 1'b0;
        rd('h31); chk("save1_masked", csr_rvalue, 32'hDEAD_0000);
        wr('h0C, 32'hFFFF_FFFF, 32'h1C00_80FF);
        rd('h0C); chk("eentry_low_zero", csr_rvalue, 32'h1C00_80C0);

        // Exception entry and return
        wr('h00, 32'hFFFF_FFFF, 32'h7);
        wb_ex = 1'b1; wb_ecode = 6'hB; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100;
        cycle();
        wb_ex = 1'b0;
        rd('h00); chk("ex_crmd_lo",  32'(csr_rvalue[2:0]), 32'h0);
        rd('h01); chk("ex_prmd_lo",  32'(csr_rvalue[2:0]), 32'h7);
        rd('h06); chk("ex_era",      csr_rvalue, 32'h1C00_0100);
        rd('h05); chk("ex_ecode",    32'(csr_rvalue[21:16]), 32'hB);
        chk("ex_plv", 32'(csr_plv), 32'h0);
        ertn_flush = 1'b1;
        cycle();
        ertn_flush = 1'b0;
        rd('h00); chk("ertn_crmd_lo", 32'(csr_rvalue[2:0]), 32'h7);

        // ADE exception loads BADV; the coincident CSR write is dropped
        wb_ex = 1'b1; wb_ecode = 6'h8; wb_esubcode = 9'h1; wb_vaddr = 32'h0000_0003;
        csr_we = 1'b1; csr_num = W'('h30); csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h1234_5678;
        cycle();
        wb_ex = 1'b0; csr_we = 1'b0;
        rd('h07); chk("ade_badv",     csr_rvalue, 32'h3);
        rd('h05); chk("ade_esubcode", 32'(csr_rvalue[30:22]), 32'h1);
        rd('h30); chk("ade_save0",    csr_rvalue, 32'h0);

        // Periodic timer, InitVal=2
        wr('h41, 32'hFFFF_FFFF, 32'h0000_000B);
        for (int i = 0; i < 10; i++) begin
            rd('h42); chk("tval_seq", csr_rvalue, (i <= 8) ? 32'(8 - i) : 32'h8);
            rd('h05);
            if (i == 7) chk("is11_before", 32'(csr_rvalue[11]), 32'h0);
            if (i == 8) chk("is11_set",    32'(csr_rvalue[11]), 32'h1);
            cycle();
        end
        wr('h44, 32'h1, 32'h1);
        rd('h05); chk("ticlr_clear", 32'(csr_rvalue[11]), 32'h0);
        for (int i = 0; i < 20 && m['h42] != 32'h1; i++) cycle();
        rd('h42); chk("tval_at_one", csr_rvalue, 32'h1);
        wr('h44, 32'h1, 32'h1);
        rd('h05); chk("set_beats_clear", 32'(csr_rvalue[11]), 32'h1);
        wr('h41, 32'hFFFF_FFFF, 32'h0);
        wr('h44, 32'h1, 32'h1);

        // Interrupt request from a hardware line
        wr('h04, 32'hFFFF_FFFF, 32'h0000_0004);
        wr('h00, 32'hFFFF_FFFF, 32'h0000_0004);
        hw_int_in = 8'h01;
        #1; chk("hwint_not_yet", 32'(has_int), 32'h0);
        cycle();
        chk("hwint_has_int", 32'(has_int), 32'h1);
        wr('h00, 32'h0000_0004, 32'h0);
        chk("ie_off_has_int", 32'(has_int), 32'h0);
        hw_int_in = 8'h00;

        // Reset in the middle of a countdown with the timer interrupt pending
        wr('h04, 32'hFFFF_FFFF, 32'h0000_0800);
        wr('h00, 32'hFFFF_FFFF, 32'h0000_0004);
        wr('h41, 32'hFFFF_FFFF, 32'h0000_0007);
        repeat (6) cycle();
        rd('h42); chk("pre_rst_tval", csr_rvalue, 32'h3);
        chk("pre_rst_has_int", 32'(has_int), 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rd('h00); chk("mid_rst_crmd", csr_rvalue, 32'h0000_0008);
        rd('h41); chk("mid_rst_en",   32'(csr_rvalue[0]), 32'h0);
        rd('h42); chk("mid_rst_tval", csr_rvalue, 32'h0);
        rd('h05); chk("mid_rst_is11", 32'(csr_rvalue[11]), 32'h0);
        chk("mid_rst_has_int", 32'(has_int), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            csr_num     = W'(c_rand_addr[$urandom_range(0, 16)]);
            csr_re      = $urandom_range(0, 1) == 1;
            csr_we      = $urandom_range(0, 1) == 1;
            csr_wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue  = $urandom;
            if (csr_num == W'('h41)) csr_wvalue = 32'($urandom_range(0, 31));
            wb_ex       = ($urandom_range(0, 15) == 0);
            ertn_flush  = ($urandom_range(0, 15) == 0);
            wb_ecode    = ($urandom_range(0, 2) == 0) ? 6'h8 : 6'($urandom_range(0, 63));
            wb_esubcode = 9'($urandom);
            wb_pc       = $urandom;
            wb_vaddr    = $urandom;
            hw_int_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            ipi_int_in  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        t = 32'(checks);
        $display("CHECKS %0d ERRORS %0d", t, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter CSR_NUM_WIDTH, default 14, CSR address width (matches csr_num from WB).
REQ-002 SHALL have parameter TIMER_ID, default 32'h0, reset value of TID.
REQ-003 SHALL have: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have: csr_re  in  1  read strobe; csr_num  in  CSR_NUM_WIDTH  CSR address.
REQ-006 SHALL have: csr_rvalue  out  32  read data.
REQ-007 SHALL have: csr_we  in  1, csr_wmask  in  32, csr_wvalue  in  32  masked write port.
REQ-008 SHALL have: wb_ex  in  1, wb_ecode  in  6, wb_esubcode  in  9, wb_pc  in  32, wb_vaddr  in  32  exception report from WB.
REQ-009 SHALL have: ertn_flush  in  1  exception-return commit.
REQ-010 SHALL have: hw_int_in  in  8  level hardware interrupts; ipi_int_in  in  1  inter-processor interrupt.
REQ-011 SHALL have: csr_plv  out  2  current privilege; has_int  out  1  interrupt pending-and-enabled.
REQ-012 SHALL have: ex_entry  out  32  exception target (EENTRY); ertn_entry  out  32  return target (ERA).

Function
REQ-013 SHALL implement CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-014 Read SHALL be combinational from current state; unmapped address and TICLR read 32'h0; csr_rvalue qualified by nothing (csr_re informational).
REQ-015 Write SHALL take effect next edge as new = (old & ~wmask) | (wvalue & wmask), restricted to writable fields; read-only/reserved bits stay at defined values.
REQ-016 Same-cycle read and write of one CSR SHALL return the pre-write value (csrxchg semantics).
REQ-017 Fields: CRMD PLV[1:0] IE[2] DA[3] PG[4]; PRMD PPLV[1:0] PIE[2]; ECFG LIE[12:0] with bit10 fixed 0; ESTAT IS[1:0] writable, IS[9:2]/IS[11]/IS[12] hardware, Ecode[21:16], EsubCode[30:22] hardware-only; EENTRY VA[31:6], [5:0]=0; TCFG En[0] Periodic[1] InitVal[31:2]; TVAL read-only.
REQ-018 On wb_ex=1 and ertn_flush=0: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=wb_pc, ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode.
REQ-019 On wb_ex with wb_ecode=6'h8 (ADE), BADV SHALL load wb_vaddr; other ecodes leave BADV.
REQ-020 On ertn_flush=1: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; ertn_flush SHALL take priority over simultaneous wb_ex (no exception state change).
REQ-021 When wb_ex or ertn_flush is 1, csr_we SHALL be ignored that cycle.
REQ-022 ESTAT.IS[9:2] SHALL register hw_int_in each cycle; IS[12] SHALL register ipi_int_in each cycle.
REQ-023 has_int SHALL be combinational: ((ESTAT.IS[12:0] & ECFG.LIE) != 0) && CRMD.IE.
REQ-024 Write to TCFG SHALL load TVAL <= {new InitVal,2'b00} next edge, overriding counting.
REQ-025 Otherwise while TCFG.En=1: TVAL!=0 -> TVAL-1; TVAL==1 -> 0 and IS[11]<=1; TVAL==0 -> reload {InitVal,2'b00} if Periodic else hold 0.
REQ-026 Periodic period SHALL be InitVal*4+1 cycles; InitVal=0 SHALL never raise IS[11].
REQ-027 TICLR write with (wvalue[0] & wmask[0])=1 SHALL clear IS[11]; simultaneous timer set SHALL win.
REQ-028 En=0 SHALL freeze TVAL.
REQ-029 csr_plv = CRMD.PLV; ex_entry = EENTRY; ertn_entry = ERA; all combinational from state.

Reset
REQ-030 On reset: CRMD = 32'h8 (PLV=0, IE=0, DA=1, PG=0); ECFG.LIE=0; ESTAT.IS[1:0]=0, IS[11]=0; TCFG.En=0; TID=TIMER_ID.
REQ-031 On reset PRMD, ERA, BADV, EENTRY, SAVE0-3, TVAL, Ecode, EsubCode SHALL be 0.
REQ-032 Reset SHALL override wb_ex, ertn_flush, csr_we and timer in the same cycle; outputs reflect reset values the cycle after.

Verification
REQ-033 Write SAVE1 wvalue=32'hDEADBEEF wmask=32'hFFFF0000, then read -> 32'hDEAD0000; same-cycle read during write -> old 32'h0.
REQ-034 CRMD=32'h7 (PLV=3, IE=1), wb_ex ecode=6'hB pc=32'h1C000100 -> next cycle CRMD[2:0]=0, PRMD[2:0]=3'b111, ERA=32'h1C000100, ESTAT[21:16]=6'hB, csr_plv=0; then ertn_flush -> CRMD[2:0]=3'b111.
REQ-035 wb_ex ecode=6'h8 esubcode=9'h1 vaddr=32'h0000_0003 -> BADV=32'h3, ESTAT[30:22]=9'h1; simultaneous csr_we to SAVE0 discarded.
REQ-036 TCFG=32'h0000_000B (InitVal=2, En, Periodic) -> TVAL 8,7,...,1,0, IS[11]=1 on 1->0, reload 8; TICLR write 1 -> IS[11]=0; set and clear same cycle -> IS[11]=1.
REQ-037 ECFG.LIE=13'h004, CRMD.IE=1, hw_int_in=8'h01 -> has_int=1 one cycle later; CRMD.IE=0 -> has_int=0.
REQ-038 Reset asserted mid-countdown with pending IS[11] -> CRMD=32'h8, TCFG.En=0, TVAL=0, IS[11]=0, has_int=0.
